// File: rtl/uart_pkg.sv
// Shared definitions for the debug UART: data width, default bit timing and receiver FSM states.
package uart_pkg;

    localparam int unsigned UART_DATA_BITS    = 8;
    localparam int unsigned UART_CLKS_PER_BIT = 1085;

    typedef enum logic [2:0] {
        StIdle,
        StStart,
        StData,
        StParity,
        StStop,
        StWaitIdle
    } uart_rx_state_t;

endpackage

// File: rtl/bit_sync.sv
// Multi-flop synchronizer for asynchronous single-bit inputs, with selectable depth and reset value.
module bit_sync #(
    parameter int unsigned Stages   = 2,
    parameter logic        ResetVal = 1'b0
) (
    input  logic clk,
    input  logic reset_n,
    input  logic d,
    output logic q
);

    logic [Stages-1:0] sync_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync_q <= {Stages{ResetVal}};
        end else begin
            sync_q <= {sync_q[Stages-2:0], d};
        end
    end

    assign q = sync_q[Stages-1];

endmodule

// File: rtl/debug_uart_rx.sv
// Debug UART receiver: 8N1 (or 8E1 with DEBUG_UART_RX_PARITY_EN), LSB first, mid-bit majority
// sampling, single-entry holding register on a valid/ready handshake.
module debug_uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned CLKS_PER_BIT = UART_CLKS_PER_BIT,
    parameter int unsigned SYNC_STAGES  = 2
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic                      rx,
    output logic [UART_DATA_BITS-1:0] data,
    output logic                      valid,
    input  logic                      ready,
    output logic                      frame_err,
    output logic                      parity_err,
    output logic                      overrun,
    output logic                      busy
);

    localparam int unsigned CntW = $clog2(CLKS_PER_BIT);
    localparam int unsigned BitW = $clog2(UART_DATA_BITS);
    localparam int unsigned Half = CLKS_PER_BIT / 2;

    localparam logic [CntW-1:0] CntLast = CntW'(CLKS_PER_BIT - 1);
    localparam logic [CntW-1:0] SmpA    = CntW'(Half - 1);
    localparam logic [CntW-1:0] SmpB    = CntW'(Half);
    localparam logic [CntW-1:0] SmpC    = CntW'(Half + 1);
    localparam logic [BitW-1:0] BitLast = BitW'(UART_DATA_BITS - 1);

    logic rx_s;

    bit_sync #(
        .Stages   (SYNC_STAGES),
        .ResetVal (1'b1)
    ) u_rx_sync (
        .clk     (clk),
        .reset_n (reset_n),
        .d       (rx),
        .q       (rx_s)
    );

    uart_rx_state_t            state_q, state_d;
    logic [CntW-1:0]           cnt_q, cnt_d;
    logic [BitW-1:0]           bitn_q, bitn_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d;
    logic                      smp_a_q, smp_b_q;
    logic [UART_DATA_BITS-1:0] data_q, data_d;
    logic                      valid_q, valid_d;
    logic                      frame_err_q, frame_err_d;
    logic                      overrun_q, overrun_d;
    logic                      deliver;
    logic                      maj;
    logic                      mid;
    logic                      wrap;
`ifdef DEBUG_UART_RX_PARITY_EN
    logic                      par_bad_q, par_bad_d;
    logic                      parity_err_q, parity_err_d;
`endif

    // The third sample is the live rx_s, so the vote is usable on the SmpC cycle itself.
    assign maj  = (smp_a_q & smp_b_q) | (smp_a_q & rx_s) | (smp_b_q & rx_s);
    assign mid  = (cnt_q == SmpC);
    assign wrap = (cnt_q == CntLast);

    always_comb begin
        state_d     = state_q;
        cnt_d       = wrap ? '0 : cnt_q + 1'b1;
        bitn_d      = bitn_q;
        shift_d     = shift_q;
        deliver     = 1'b0;
        frame_err_d = 1'b0;
`ifdef DEBUG_UART_RX_PARITY_EN
        par_bad_d    = par_bad_q;
        parity_err_d = 1'b0;
`endif
        case (state_q)
            StIdle: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = StStart;
                end
            end
            StStart: begin
                if (mid && maj) begin
                    state_d = StIdle;
                end else if (wrap) begin
                    state_d = StData;
                    bitn_d  = '0;
                end
            end
            StData: begin
                if (mid) begin
                    shift_d[bitn_q] = maj;
                end
                if (wrap) begin
                    if (bitn_q == BitLast) begin
`ifdef DEBUG_UART_RX_PARITY_EN
                        state_d = StParity;
`else
                        state_d = StStop;
`endif
                    end else begin
                        bitn_d = bitn_q + 1'b1;
                    end
                end
            end
`ifdef DEBUG_UART_RX_PARITY_EN
            StParity: begin
                // Even parity: the received bit must equal the XOR of the data bits.
                if (mid) begin
                    par_bad_d = maj ^ (^shift_q);
                end
                if (wrap) begin
                    state_d = StStop;
                end
            end
`endif
            StStop: begin
                if (mid) begin
                    if (!maj) begin
                        frame_err_d = 1'b1;
                        state_d     = StWaitIdle;
`ifdef DEBUG_UART_RX_PARITY_EN
                    end else if (par_bad_q) begin
                        parity_err_d = 1'b1;
                        state_d      = StIdle;
`endif
                    end else begin
                        deliver = 1'b1;
                        state_d = StIdle;
                    end
                end
            end
            StWaitIdle: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // Holding register: a same-cycle consume frees the slot for the incoming byte.
    always_comb begin
        data_d    = data_q;
        valid_d   = valid_q;
        overrun_d = 1'b0;
        if (deliver) begin
            if (!valid_q || ready) begin
                data_d  = shift_q;
                valid_d = 1'b1;
            end else begin
                overrun_d = 1'b1;
            end
        end else if (valid_q && ready) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            bitn_q      <= '0;
            shift_q     <= '0;
            smp_a_q     <= 1'b1;
            smp_b_q     <= 1'b1;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            bitn_q      <= bitn_d;
            shift_q     <= shift_d;
            if (cnt_q == SmpA) smp_a_q <= rx_s;
            if (cnt_q == SmpB) smp_b_q <= rx_s;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
        end
    end

`ifdef DEBUG_UART_RX_PARITY_EN
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            par_bad_q    <= 1'b0;
            parity_err_q <= 1'b0;
        end else begin
            par_bad_q    <= par_bad_d;
            parity_err_q <= parity_err_d;
        end
    end

    assign parity_err = parity_err_q;
`else
    assign parity_err = 1'b0;
`endif

    assign data      = data_q;
    assign valid     = valid_q;
    assign frame_err = frame_err_q;
    assign overrun   = overrun_q;
    assign busy      = (state_q != StIdle);

endmodule

// File: tb/tb_debug_uart_rx.sv
// Directed bench for debug_uart_rx at 16 clocks per bit; define DEBUG_UART_RX_PARITY_EN for the
// parity steps.
module tb_debug_uart_rx;

    localparam int unsigned CPB = 16;
    localparam int unsigned SS  = 2;

    logic       clk;
    logic       reset_n;
    logic       rx;
    logic [7:0] data;
    logic       valid;
    logic       ready;
    logic       frame_err;
    logic       parity_err;
    logic       overrun;
    logic       busy;

    int tests = 0;
    int fails = 0;

    int cyc = 0;
    int valid_cycles = 0;
    int valid_rises = 0;
    int rise_cyc = 0;
    int frame_cnt = 0;
    int par_cnt = 0;
    int ovr_cnt = 0;
    logic valid_prev = 1'b0;
    int t_start = 0;

`ifdef DEBUG_UART_RX_PARITY_EN
    logic bad_par = 1'b0;
`endif

    debug_uart_rx #(
        .CLKS_PER_BIT (CPB),
        .SYNC_STAGES  (SS)
    ) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rx         (rx),
        .data       (data),
        .valid      (valid),
        .ready      (ready),
        .frame_err  (frame_err),
        .parity_err (parity_err),
        .overrun    (overrun),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Event counters sampled mid-cycle.
    always @(negedge clk) begin
        if (valid) valid_cycles = valid_cycles + 1;
        if (valid && !valid_prev) begin
            valid_rises = valid_rises + 1;
            rise_cyc    = cyc;
        end
        if (frame_err)  frame_cnt = frame_cnt + 1;
        if (parity_err) par_cnt   = par_cnt + 1;
        if (overrun)    ovr_cnt   = ovr_cnt + 1;
        valid_prev = valid;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic drive_bit(input logic v);
        rx = v;
        repeat (CPB) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int stop_bits);
        t_start = cyc;
        drive_bit(1'b0);
        for (int i = 0; i < 8; i++) drive_bit(d[i]);
`ifdef DEBUG_UART_RX_PARITY_EN
        drive_bit((^d) ^ bad_par);
`endif
        for (int i = 0; i < stop_bits; i++) drive_bit(stop_v);
        rx = 1'b1;
    endtask

    int vc0, vr0, fc0, pc0, oc0;

    task automatic snap();
        vc0 = valid_cycles;
        vr0 = valid_rises;
        fc0 = frame_cnt;
        pc0 = par_cnt;
        oc0 = ovr_cnt;
    endtask

    initial begin
        reset_n = 1'b0;
        rx      = 1'b1;
        ready   = 1'b1;
        repeat (3) @(negedge clk);
        check("reset_valid", valid, 0);
        check("reset_data", data, 8'h00);
        check("reset_busy", busy, 0);
        check("reset_frame_err", frame_err, 0);
        check("reset_parity_err", parity_err, 0);
        check("reset_overrun", overrun, 0);
        reset_n = 1'b1;
        repeat (CPB) @(negedge clk);

        // Plain byte with ready held high.
        snap();
        send_frame(8'hA5, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("a5_data", data, 8'hA5);
        check("a5_valid_cycles", 32'(valid_cycles - vc0), 1);
        check("a5_frame_err", 32'(frame_cnt - fc0), 0);
        check("a5_overrun", 32'(ovr_cnt - oc0), 0);
        check("a5_parity_err", 32'(par_cnt - pc0), 0);
        check("a5_latency_window",
              32'((rise_cyc - t_start) >= 150 && (rise_cyc - t_start) <= 165), 1);
        check("a5_busy_after", busy, 0);

        // Short low glitch.
        snap();
        rx = 1'b0;
        repeat (5) @(negedge clk);
        check("glitch_busy_during", busy, 1);
        rx = 1'b1;
        repeat (16) @(negedge clk);
        check("glitch_busy_after", busy, 0);
        check("glitch_no_valid", 32'(valid_rises - vr0), 0);
        check("glitch_no_frame_err", 32'(frame_cnt - fc0), 0);

        // Stop bit held low for two bit times.
        snap();
        send_frame(8'h3C, 1'b0, 2);
        check("break_busy_wait_idle", busy, 1);
        check("break_frame_err", 32'(frame_cnt - fc0), 1);
        check("break_no_valid", 32'(valid_rises - vr0), 0);
        repeat (2 * CPB) @(negedge clk);
        check("break_busy_released", busy, 0);
        snap();
        send_frame(8'h55, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("after_break_data", data, 8'h55);
        check("after_break_valid", 32'(valid_rises - vr0), 1);

        // Overrun with the consumer stalled.
        ready = 1'b0;
        snap();
        send_frame(8'h11, 1'b1, 1);
        send_frame(8'h22, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("ovr_valid_held", valid, 1);
        check("ovr_data_held", data, 8'h11);
        check("ovr_pulse", 32'(ovr_cnt - oc0), 1);
        check("ovr_single_rise", 32'(valid_rises - vr0), 1);
        ready = 1'b1;
        @(negedge clk);
        check("ovr_valid_drop", valid, 0);
        check("ovr_data_kept", data, 8'h11);

        // Reset during data bit 4.
        drive_bit(1'b0);
        drive_bit(1'b0);
        drive_bit(1'b1);
        drive_bit(1'b1);
        drive_bit(1'b1);
        rx = 1'b1;
        repeat (CPB / 2) @(negedge clk);
        check("mid_frame_busy", busy, 1);
        reset_n = 1'b0;
        #1;
        check("rst_busy", busy, 0);
        check("rst_data", data, 8'h00);
        check("rst_valid", valid, 0);
        repeat (4) @(negedge clk);
        reset_n = 1'b1;
        repeat (2 * CPB) @(negedge clk);
        snap();
        send_frame(8'h7E, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("post_rst_data", data, 8'h7E);
        check("post_rst_valid", 32'(valid_rises - vr0), 1);

`ifdef DEBUG_UART_RX_PARITY_EN
        snap();
        bad_par = 1'b1;
        send_frame(8'h01, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("par_bad_pulse", 32'(par_cnt - pc0), 1);
        check("par_bad_no_valid", 32'(valid_rises - vr0), 0);
        snap();
        bad_par = 1'b0;
        send_frame(8'h01, 1'b1, 1);
        repeat (4) @(negedge clk);
        check("par_good_data", data, 8'h01);
        check("par_good_valid", 32'(valid_rises - vr0), 1);
        check("par_good_no_err", 32'(par_cnt - pc0), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/debug_uart_rx.md
# debug_uart_rx

Serial receiver for the debug UART input (`uart_rx` pin) on the 125 MHz RGMII-derived system clock. It is the receive counterpart of the existing debug UART transmitter. It deframes 8N1 asynchronous serial data, LSB first, using mid-bit majority sampling, and presents each byte on a valid/ready handshake to the command logic in `top`.

## Interface
- `CLKS_PER_BIT`, 1085: clocks per bit (125 MHz / 115200). Legal range is 16 or more.
- `SYNC_STAGES`, 2: flops in the `rx` input synchronizer. Legal range is 2 or more.
- `clk`  in  1  system clock; all logic is on its rising edge.
- `reset_n`  in  1  asynchronous, active-low reset.
- `rx`  in  1  asynchronous serial input; idles high.
- `data`  out  8  received byte; stable while `valid` is high.
- `valid`  out  1  `data` holds an unconsumed byte.
- `ready`  in  1  consumer accepts `data` on any cycle where `valid && ready`.
- `frame_err`  out  1  one-cycle pulse when a stop bit is sampled low.
- `parity_err`  out  1  one-cycle pulse on a parity mismatch; tied 0 when parity is compiled out.
- `overrun`  out  1  one-cycle pulse when a completed byte is dropped because the holding register is full.
- `busy`  out  1  receiver is not in IDLE.

## Operation
- Synchronizer: `SYNC_STAGES` flops, reset to 1; its output is `rx_s`. All decisions use `rx_s`.
- Counters:
  - `cnt` runs 0..CLKS_PER_BIT-1 within each bit period.
  - `bitn` runs 0..7.
  - HALF = CLKS_PER_BIT/2, using floor division.
- Sampling: majority of `rx_s` at cnt = HALF-1, HALF and HALF+1. The result is valid at cnt = HALF+1.
- FSM states: IDLE, START, DATA, PARITY (macro only), STOP, WAIT_IDLE.
  - IDLE → START when `rx_s`==0; `cnt` is cleared.
  - START: if the majority is 1, this is a false start; go to IDLE with no outputs. If 0, continue. At cnt wrap, go to DATA with `bitn`=0.
  - DATA: at the majority point, shift the sample into the byte at bit `bitn` (LSB first). At cnt wrap, increment `bitn`. After bit 7, go to PARITY (if compiled in) or STOP.
  - STOP: at the majority point, take one of three actions:
    - Majority 0: pulse `frame_err`, discard the byte, go to WAIT_IDLE.
    - Majority 1 with a parity error pending: pulse `parity_err`, discard the byte, go to IDLE.
    - Majority 1 otherwise: deliver the byte, go to IDLE.
  - WAIT_IDLE → IDLE when `rx_s`==1. This covers break conditions.
- Delivery to the holding register:
  - If `valid`==0, or `valid && ready` in the same cycle: load `data`, `valid`=1.
  - Otherwise: pulse `overrun`, drop the new byte, and keep the old `data`.
- `valid` clears on `valid && ready` when no delivery occurs in that same cycle.
- Returning to IDLE at mid-stop means the next start edge is detected in the following frame. Back-to-back frames are supported.

## Timing
- Reset values:
  - `data`=0, `valid`=0, `frame_err`=0, `parity_err`=0, `overrun`=0, `busy`=0.
  - FSM in IDLE; synchronizer flops = 1.
- Reset asserted mid-frame aborts immediately. After release, wait in IDLE for the next falling edge of `rx_s`.
- `valid` rises one clock after the stop-bit cnt = HALF+1 cycle.
- End-to-end latency: `valid` rises ≈ SYNC_STAGES + 9·CLKS_PER_BIT + HALF + 3 clocks after the `rx` falling edge, or +CLKS_PER_BIT with parity.
- Error and overrun pulses are exactly 1 clock wide and are coincident with the cycle `valid` would have risen.
- Glitch rejection: a low pulse shorter than HALF-1 clocks produces no output.
- Tolerates ±4% baud mismatch at 8N1.

## Configuration
- `DEBUG_UART_RX_PARITY_EN` defined:
  - Adds the PARITY state after DATA: one bit, even parity over the 8 data bits, same majority sampling.
  - A mismatch pulses `parity_err` and discards the byte. The stop bit is still checked.
  - If the stop bit is also low, `frame_err` takes precedence and `parity_err` does not pulse.
- Undefined: there is no PARITY state, `parity_err` is tied 0, and the frame is 8N1.

## Structure
- Shared package `uart_pkg`:
  - typedef `uart_rx_state_t` (FSM states).
  - `UART_DATA_BITS`=8.
  - default `UART_CLKS_PER_BIT`=1085.
- Sub-module `bit_sync`: a parameterized-depth synchronizer with a parameterized reset value. The same module is reused for other asynchronous pins (`phy_mdint`, `clock_ftest_ld`).

## Test plan
- CLKS_PER_BIT=16, `ready`=1, send 0xA5 → one-cycle `valid` with `data`=0xA5; no error pulses.
- `rx` low for 5 clocks, then high → no `valid`, no errors; `busy` returns to 0 within 16 clocks.
- Send 0x3C with the stop bit held low for 2 bit times → `frame_err` pulses once, no `valid`. The FSM stays in WAIT_IDLE until `rx` is high, then 0x55 is received correctly.
- `ready`=0, send 0x11 then 0x22 → `data`=0x11 held with `valid`=1; `overrun` pulses at the end of the 0x22 frame. Raise `ready` → `valid` drops.
- Assert `reset_n` during data bit 4 → all outputs are 0 immediately; the next frame 0x7E is received correctly.
- With `DEBUG_UART_RX_PARITY_EN`, send 0x01 with parity bit 0 → `parity_err` pulse, no `valid`. Send 0x01 with parity bit 1 → `data`=0x01.
